// File: rtl/bram_matmul_test_if.sv
// Host-side bus for the BRAM bring-up block: run control, both BRAM A ports
// and the product stream coming back.
interface bram_matmul_test_if;
  logic        start;
  logic        wb_ena;
  logic [11:0] wb_addra;
  logic [63:0] wb_dina;
  logic [7:0]  wb_wea;
  logic        in_ena;
  logic [13:0] in_addra;
  logic [63:0] in_dina;
  logic [7:0]  in_wea;
  logic [63:0] out_bram;

  modport master (
    output start, wb_ena, wb_addra, wb_dina, wb_wea,
    output in_ena, in_addra, in_dina, in_wea,
    input  out_bram
  );

  modport slave (
    input  start, wb_ena, wb_addra, wb_dina, wb_wea,
    input  in_ena, in_addra, in_dina, in_wea,
    output out_bram
  );
endinterface

// File: rtl/bram_matmul_test.sv
// BRAM bring-up block for the matrix-multiply datapath.
// Two 64-bit BRAMs (weight/bias and input) are written by the host on port A.
// A start-triggered sequencer reads both on port B and streams the lane-wise
// fixed-point product of each word pair on out_bram, two edges after issue.
module bram_matmul_test #(
  parameter int WIDTH             = 16,
  parameter int FRAC_WIDTH        = 8,
  parameter int BLOCK_SIZE        = 2,
  parameter int CHUNK_SIZE        = 4,
  parameter int INNER_DIMENSION   = 8,
  parameter int W_OUTER_DIMENSION = 16,
  parameter int I_OUTER_DIMENSION = 16,
  parameter int ROW_SIZE_MAT_C    = I_OUTER_DIMENSION / BLOCK_SIZE,
  parameter int COL_SIZE_MAT_C    = W_OUTER_DIMENSION / BLOCK_SIZE
) (
  input logic                clk,
  input logic                rst_n,
  bram_matmul_test_if.slave  bus
);

  localparam int WORD_W   = WIDTH * CHUNK_SIZE;
  localparam int PROD_W   = 2 * WIDTH;
  localparam int WB_WORDS = INNER_DIMENSION * W_OUTER_DIMENSION / CHUNK_SIZE;
  localparam int IN_WORDS = INNER_DIMENSION * I_OUTER_DIMENSION / CHUNK_SIZE;
  localparam int RUN_LEN  = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
  localparam int K_W      = $clog2(RUN_LEN) + 1;
  localparam int WB_DEPTH = 4096;
  localparam int IN_DEPTH = 16384;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [K_W-1:0]      r_k;
  logic [K_W-1:0]      w_nextK;
  logic                r_drainCnt;
  logic                w_nextDrainCnt;
  logic                w_rdEn;
  logic [11:0]         w_wbAddrB;
  logic [13:0]         w_inAddrB;

  logic [WORD_W-1:0]   r_wbMem [WB_DEPTH];
  logic [WORD_W-1:0]   r_inMem [IN_DEPTH];
  logic [WORD_W-1:0]   r_wbDout;
  logic [WORD_W-1:0]   r_inDout;
  logic                r_dataValid;

  logic signed [PROD_W-1:0] w_prod  [CHUNK_SIZE];
  logic signed [PROD_W-1:0] w_shift [CHUNK_SIZE];
  logic [WORD_W-1:0]        w_lanes;
  logic [WORD_W-1:0]        r_outBram;

  // Both BRAMs cycle through their whole contents, wrapping every 32 words.
  assign w_wbAddrB = 12'(r_k % K_W'(WB_WORDS));
  assign w_inAddrB = 14'(r_k % K_W'(IN_WORDS));

  // Sequencer state, run index and drain counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_drainCnt <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_k        <= w_nextK;
      r_drainCnt <= w_nextDrainCnt;
    end
  end

  // Next-state logic; a read pair is issued on every RUN cycle.
  always_comb begin
    w_nextState    = r_state;
    w_nextK        = r_k;
    w_nextDrainCnt = r_drainCnt;
    w_rdEn         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nextState = S_RUN;
          w_nextK     = '0;
        end
      end
      S_RUN: begin
        w_rdEn  = 1'b1;
        w_nextK = r_k + 1'b1;
        if (r_k == K_W'(RUN_LEN - 1)) begin
          w_nextState    = S_DRAIN;
          w_nextDrainCnt = 1'b0;
        end
      end
      S_DRAIN: begin
        if (r_drainCnt) begin
          w_nextState = S_DONE;
        end else begin
          w_nextDrainCnt = 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.start) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Weight BRAM port A: byte-masked host writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.wb_ena) begin
      for (int i = 0; i < WORD_W / 8; i++) begin
        if (bus.wb_wea[i]) begin
          r_wbMem[bus.wb_addra][8*i +: 8] <= bus.wb_dina[8*i +: 8];
        end
      end
    end
  end

  // Input BRAM port A: byte-masked host writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.in_ena) begin
      for (int i = 0; i < WORD_W / 8; i++) begin
        if (bus.in_wea[i]) begin
          r_inMem[bus.in_addra][8*i +: 8] <= bus.in_dina[8*i +: 8];
        end
      end
    end
  end

  // Port B registered reads; sampling before the port-A update gives read-first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wbDout    <= '0;
      r_inDout    <= '0;
      r_dataValid <= 1'b0;
    end else begin
      r_dataValid <= w_rdEn;
      if (w_rdEn) begin
        r_wbDout <= r_wbMem[w_wbAddrB];
        r_inDout <= r_inMem[w_inAddrB];
      end
    end
  end

  // Lane-wise signed product, arithmetic shift, wrap to the element width.
  always_comb begin
    w_lanes = '0;
    for (int j = 0; j < CHUNK_SIZE; j++) begin
      w_prod[j]  = PROD_W'($signed(r_inDout[WIDTH*j +: WIDTH]))
                 * PROD_W'($signed(r_wbDout[WIDTH*j +: WIDTH]));
      w_shift[j] = w_prod[j] >>> FRAC_WIDTH;
      w_lanes[WIDTH*j +: WIDTH] = w_shift[j][WIDTH-1:0];
    end
  end

  // Output register only moves when fresh BRAM data arrives, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outBram <= '0;
    end else if (r_dataValid) begin
      r_outBram <= w_lanes;
    end
  end

  assign bus.out_bram = r_outBram;

endmodule

// File: tb/tb_bram_matmul_test.sv
// Scoreboard bench for bram_matmul_test: stimulus pushes the expected word of
// every run step into a queue, a monitor pops and compares each output beat.
module tb_bram_matmul_test;

  localparam int RUN_LEN  = 64;
  localparam int MEM_WRAP = 32;

  logic clk;
  logic rst_n;
  bram_matmul_test_if busIf();

  bram_matmul_test dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          testsRun;
  int          testsFailed;
  logic [63:0] expQ [$];
  logic [63:0] expOut [MEM_WRAP];
  bit          monDone;
  int          runIdx;
  event        runLaunched;

  // Hand-derived lane results (Q8.8, product >>> 8, low 16 bits kept):
  //   0x0100*0x0200=0x0200  0x0100*0xFE00=0xFE00  0x0100*0x0080=0x0080
  //   0x7FFF*0x7FFF=0x3FFF0001 -> 0x3FFF00 -> 0xFF00
  //   0x8000*0x8000=0x40000000 -> 0x400000 -> 0x0000
  //   0xFF00*0x0080=-0x8000    -> -0x80    -> 0xFF80
  //   0xFFFF*0x0001=-1         -> -1       -> 0xFFFF
  localparam logic [63:0] ONES_Q88   = 64'h0100_0100_0100_0100;
  localparam logic [63:0] PROD_WB    = 64'h0200_FE00_0080_0300;
  localparam logic [63:0] WRAP_IN    = 64'h7FFF_8000_FF00_FFFF;
  localparam logic [63:0] WRAP_WB    = 64'h7FFF_8000_0080_0001;
  localparam logic [63:0] WRAP_EXP   = 64'hFF00_0000_FF80_FFFF;
  localparam logic [63:0] BE_FULL    = 64'h1111_2222_3333_4444;
  localparam logic [63:0] BE_EXP     = 64'h1111_2222_3333_44FF;
  localparam logic [63:0] COLL_NEW   = 64'h0500_0500_0500_0500;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic writeWord(input bit isWb, input logic [13:0] addr,
                           input logic [63:0] data, input logic [7:0] wea);
    @(negedge clk);
    if (isWb) begin
      busIf.wb_ena   = 1'b1;
      busIf.wb_addra = addr[11:0];
      busIf.wb_dina  = data;
      busIf.wb_wea   = wea;
    end else begin
      busIf.in_ena   = 1'b1;
      busIf.in_addra = addr;
      busIf.in_dina  = data;
      busIf.in_wea   = wea;
    end
    @(negedge clk);
    busIf.wb_ena = 1'b0;
    busIf.in_ena = 1'b0;
  endtask

  // Raise start so it is sampled at the next edge, then hand the run to the monitor.
  task automatic applyStimulus();
    @(negedge clk);
    monDone     = 1'b0;
    busIf.start = 1'b1;
    @(posedge clk);
    ->runLaunched;
  endtask

  task automatic waitMonitor(input string name);
    for (int c = 0; c < 300 && !monDone; c++) @(posedge clk);
    testsRun++;
    if (!monDone) begin
      testsFailed++;
      $display("[TB] FAIL %s: got no completed run, expected %0d outputs", name, RUN_LEN);
    end
  endtask

  task automatic pushRun();
    for (int k = 0; k < RUN_LEN; k++) expQ.push_back(expOut[k % MEM_WRAP]);
  endtask

  // Monitor: out_bram for step k appears just after edge k+2 of the run.
  initial begin
    logic [63:0] exp;
    forever begin
      @(runLaunched);
      repeat (2) @(posedge clk);
      for (int k = 0; k < RUN_LEN; k++) begin
        #1;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL run%0d k%0d: got %h, expected nothing queued", runIdx, k, busIf.out_bram);
        end else begin
          exp = expQ.pop_front();
          checkOutput($sformatf("run%0d k%0d", runIdx, k), busIf.out_bram, exp);
        end
        if (k < RUN_LEN - 1) @(posedge clk);
      end
      monDone = 1'b1;
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    monDone     = 1'b0;
    runIdx      = 0;
    rst_n       = 1'b0;
    busIf.start = 1'b1;
    busIf.wb_ena = 1'b0; busIf.wb_addra = '0; busIf.wb_dina = '0; busIf.wb_wea = '0;
    busIf.in_ena = 1'b0; busIf.in_addra = '0; busIf.in_dina = '0; busIf.in_wea = '0;

    // Reset with start high: must stay idle with a zero output.
    repeat (5) @(posedge clk);
    #1 checkOutput("reset out", busIf.out_bram, 64'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    busIf.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 checkOutput("idle after reset", busIf.out_bram, 64'h0);

    // Sequencing run: in[k] = k per lane, wb[k] = 1.0 per lane.
    for (int k = 0; k < MEM_WRAP; k++) begin
      writeWord(1'b0, 14'(k), {4{16'(k)}}, 8'hFF);
      writeWord(1'b1, 14'(k), ONES_Q88, 8'hFF);
      expOut[k] = {4{16'(k)}};
    end
    runIdx = 1;
    pushRun();
    applyStimulus();
    waitMonitor("run1 completion");

    // Start still high: DONE must hold and out_bram keep the last value.
    repeat (5) @(posedge clk);
    #1 checkOutput("hold after run", busIf.out_bram, {4{16'd31}});
    repeat (10) @(posedge clk);
    #1 checkOutput("no retrigger", busIf.out_bram, {4{16'd31}});
    @(negedge clk);
    busIf.start = 1'b0;
    repeat (2) @(posedge clk);

    // Product, wrap and byte-enable vectors, plus a read-first collision.
    writeWord(1'b0, 14'd0, ONES_Q88, 8'hFF);
    writeWord(1'b1, 14'd0, PROD_WB, 8'hFF);
    writeWord(1'b0, 14'd1, WRAP_IN, 8'hFF);
    writeWord(1'b1, 14'd1, WRAP_WB, 8'hFF);
    writeWord(1'b0, 14'd3, ONES_Q88, 8'hFF);
    writeWord(1'b1, 14'd3, BE_FULL, 8'hFF);
    writeWord(1'b1, 14'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
    expOut[0] = PROD_WB;
    expOut[1] = WRAP_EXP;
    expOut[3] = BE_EXP;
    runIdx = 2;
    for (int k = 0; k < RUN_LEN; k++) begin
      if (k >= MEM_WRAP && (k % MEM_WRAP) == 5) expQ.push_back(COLL_NEW);
      else expQ.push_back(expOut[k % MEM_WRAP]);
    end
    applyStimulus();
    // in[5] written on the same edge that captures its first read.
    repeat (5) @(posedge clk);
    @(negedge clk);
    busIf.in_ena = 1'b1; busIf.in_addra = 14'd5; busIf.in_dina = COLL_NEW; busIf.in_wea = 8'hFF;
    @(negedge clk);
    busIf.in_ena = 1'b0;
    expOut[5] = COLL_NEW;
    waitMonitor("run2 completion");
    @(negedge clk);
    busIf.start = 1'b0;
    repeat (2) @(posedge clk);

    // Abort at k=10: output of step 8 is visible, then reset clears it.
    @(negedge clk);
    busIf.start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 checkOutput("pre-abort k8", busIf.out_bram, expOut[8]);
    @(negedge clk);
    rst_n       = 1'b0;
    busIf.start = 1'b0;
    @(posedge clk);
    #1 checkOutput("abort clears out", busIf.out_bram, 64'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 checkOutput("idle after abort", busIf.out_bram, 64'h0);

    // Fresh run after the abort uses the updated contents.
    runIdx = 3;
    pushRun();
    applyStimulus();
    waitMonitor("run3 completion");
    @(negedge clk);
    busIf.start = 1'b0;
    repeat (2) @(posedge clk);

    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
